// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage. Owns the PC, fetches one word over req/gnt/rvalid,
//            holds it until the core retires it, then advances the PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  // core feedback
  input  logic            i_exec_done,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  // presented instruction
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [6:0]      o_opcode,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instret,
  output logic            o_fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("instruction_fetch: RESET_PC must be 4-byte aligned");
  end

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [31:0]     r_instret;
  logic [XLEN-1:0] w_npc;
  logic            w_retire;
  logic            w_latch;

  assign w_npc    = i_branch_taken ? i_branch_target : (r_pc + c_PC_STEP);
  assign w_retire = (r_state == S_ISSUE) && i_exec_done;
  // Only WAIT consumes rvalid, so stale beats after a reset are dropped.
  assign w_latch  = (r_state == S_WAIT) && i_imem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_REQ;
      S_REQ:   if (i_imem_gnt) w_next_state = S_WAIT;
      S_WAIT:  if (i_imem_rvalid) w_next_state = S_ISSUE;
      S_ISSUE: begin
        if (i_exec_done) begin
          w_next_state = (w_npc[1:0] == 2'b00) ? S_REQ : S_ERR;
        end
      end
      S_ERR:   w_next_state = S_ERR;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_instret <= 32'd0;
    end else begin
      if (w_latch) begin
        r_instr <= i_imem_rdata;
      end
      if (w_retire) begin
        r_pc      <= w_npc;
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  // All outputs decode from registered state only.
  assign o_imem_req    = (r_state == S_REQ);
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = (r_state == S_ISSUE);
  assign o_instr       = r_instr;
  assign o_opcode      = o_instr_valid ? r_instr[6:0] : 7'd0;
  assign o_pc          = r_pc;
  assign o_instret     = r_instret;
  assign o_fetch_err   = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench for instruction_fetch with a memory responder
//            and a PC/retire-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_exec_done;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [6:0]  o_opcode;
  logic [31:0] o_pc;
  logic [31:0] o_instret;
  logic        o_fetch_err;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic        m_err;

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_gnt      (i_imem_gnt),
    .i_imem_rvalid   (i_imem_rvalid),
    .i_imem_rdata    (i_imem_rdata),
    .i_exec_done     (i_exec_done),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .o_instr_valid   (o_instr_valid),
    .o_instr         (o_instr),
    .o_opcode        (o_opcode),
    .o_pc            (o_pc),
    .o_instret       (o_instret),
    .o_fetch_err     (o_fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    i_imem_gnt      = 1'b0;
    i_imem_rvalid   = 1'b0;
    i_imem_rdata    = 32'd0;
    i_exec_done     = 1'b0;
    i_branch_taken  = 1'b0;
    i_branch_target = 32'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    m_pc = 32'h0; m_instret = 32'd0; m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Serve one fetch: gd cycles before gnt, rvalid rd (>=1) cycles after gnt.
  task automatic fetch_one(input int gd, input int rd, input logic [31:0] data);
    int n = 0;
    while (!o_imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== m_pc) begin
      failures++;
      $display("FAIL fetch_req: req=%0b addr=%h required req=1 addr=%h", o_imem_req, o_imem_addr, m_pc);
    end
    for (int i = 0; i < gd; i++) begin
      i_imem_gnt     = 1'b0;
      i_imem_rvalid  = 1'($urandom);
      i_exec_done    = 1'($urandom);
      i_branch_taken = 1'($urandom);
      @(negedge clk);
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== m_pc || o_instret !== m_instret || o_opcode !== 7'd0) begin
        failures++;
        $display("FAIL req_hold: req=%0b addr=%h instret=%0d opcode=%h required 1 %h %0d 00",
                 o_imem_req, o_imem_addr, o_instret, o_opcode, m_pc, m_instret);
      end
    end
    clear_inputs();
    i_imem_gnt = 1'b1;
    @(negedge clk);
    i_imem_gnt = 1'b0;
    for (int i = 1; i < rd; i++) begin
      checks++;
      if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0 || o_instret !== m_instret) begin
        failures++;
        $display("FAIL wait_phase: req=%0b valid=%0b instret=%0d required 0 0 %0d",
                 o_imem_req, o_instr_valid, o_instret, m_instret);
      end
      i_exec_done    = 1'($urandom);
      i_branch_taken = 1'($urandom);
      @(negedge clk);
    end
    i_exec_done   = 1'b0;
    i_branch_taken = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = data;
    checks++;
    if (o_instr_valid !== 1'b0 || o_opcode !== 7'd0) begin
      failures++;
      $display("FAIL early_valid: valid=%0b opcode=%h required 0 00", o_instr_valid, o_opcode);
    end
    @(negedge clk);
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = $urandom;
    checks++;
    if (o_instr_valid !== 1'b1 || o_instr !== data || o_opcode !== data[6:0] || o_pc !== m_pc) begin
      failures++;
      $display("FAIL issue: valid=%0b instr=%h opcode=%h pc=%h required 1 %h %h %h",
               o_instr_valid, o_instr, o_opcode, o_pc, data, data[6:0], m_pc);
    end
  endtask

  task automatic retire(input logic br, input logic [31:0] tgt);
    i_exec_done     = 1'b1;
    i_branch_taken  = br;
    i_branch_target = tgt;
    @(negedge clk);
    clear_inputs();
    m_pc      = br ? tgt : m_pc + 32'd4;
    m_instret = m_instret + 32'd1;
    if (m_pc[1:0] != 2'b00) m_err = 1'b1;
    checks++;
    if (o_pc !== m_pc || o_instret !== m_instret || o_fetch_err !== m_err ||
        o_instr_valid !== 1'b0 || o_imem_req !== !m_err) begin
      failures++;
      $display("FAIL retire: pc=%h instret=%0d err=%0b valid=%0b req=%0b required %h %0d %0b 0 %0b",
               o_pc, o_instret, o_fetch_err, o_instr_valid, o_imem_req, m_pc, m_instret, m_err, !m_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    apply_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0 || o_opcode !== 7'd0 || o_pc !== 32'h0 ||
        o_instr !== 32'h0 || o_instret !== 32'd0 || o_fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: req=%0b valid=%0b opcode=%h pc=%h instr=%h instret=%0d err=%0b required all zero",
               o_imem_req, o_instr_valid, o_opcode, o_pc, o_instr, o_instret, o_fetch_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 3; k++) begin
      fetch_one(0, 1, 32'h0000_0033);
      retire(1'b0, 32'h0);
    end
    checks++;
    if (o_instret !== 32'd3 || o_pc !== 32'd12) begin
      failures++;
      $display("FAIL zero_wait_count: instret=%0d pc=%h required 3 0000000c", o_instret, o_pc);
    end
  endtask

  task automatic test_delayed();
    fetch_one(4, 3, 32'h0040_0093);
    retire(1'b0, 32'h0);
  endtask

  task automatic test_branch();
    logic [31:0] pc_before;
    fetch_one(1, 2, 32'h0000_0063);
    pc_before = m_pc;
    for (int i = 0; i < 3; i++) begin
      i_branch_taken  = 1'b1;
      i_branch_target = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      checks++;
      if (o_pc !== pc_before || o_instr_valid !== 1'b1 || o_instret !== m_instret) begin
        failures++;
        $display("FAIL branch_no_done: pc=%h valid=%0b instret=%0d required %h 1 %0d",
                 o_pc, o_instr_valid, o_instret, pc_before, m_instret);
      end
    end
    clear_inputs();
    retire(1'b1, 32'h0000_0040);
    checks++;
    if (o_imem_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL branch_addr: addr=%h required 00000040", o_imem_addr);
    end
    fetch_one(0, 1, 32'h0000_0013);
    retire(1'b1, m_pc + 32'd4);
  endtask

  task automatic test_wrap();
    fetch_one(0, 1, 32'h0000_006f);
    retire(1'b1, 32'hFFFF_FFFC);
    fetch_one(0, 1, 32'h0000_0013);
    retire(1'b0, 32'h0);
    checks++;
    if (o_pc !== 32'h0 || o_imem_req !== 1'b1) begin
      failures++;
      $display("FAIL wrap: pc=%h req=%0b required 00000000 1", o_pc, o_imem_req);
    end
    fetch_one(0, 1, 32'h0000_0033);
    retire(1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      logic [31:0] tgt;
      fetch_one($urandom_range(0, 3), $urandom_range(1, 3), $urandom);
      case ($urandom_range(0, 2))
        0: retire(1'b0, $urandom);
        1: begin tgt = $urandom & 32'h0000_FFFC; retire(1'b1, tgt); end
        default: retire(1'b1, m_pc + 32'd4);
      endcase
    end
  endtask

  task automatic test_misaligned();
    fetch_one(0, 1, 32'h0000_0063);
    retire(1'b1, 32'h0000_0042);
    for (int i = 0; i < 8; i++) begin
      i_imem_gnt    = 1'($urandom);
      i_imem_rvalid = 1'($urandom);
      i_exec_done   = 1'($urandom);
      @(negedge clk);
      checks++;
      if (o_fetch_err !== 1'b1 || o_imem_req !== 1'b0 || o_pc !== 32'h42 || o_instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL err_hold: err=%0b req=%0b pc=%h valid=%0b required 1 0 00000042 0",
                 o_fetch_err, o_imem_req, o_pc, o_instr_valid);
      end
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (o_fetch_err !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL err_recover: err=%0b req=%0b addr=%h required 0 1 00000000",
               o_fetch_err, o_imem_req, o_imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    fetch_one(0, 1, 32'h0000_0033);
    retire(1'b0, 32'h0);
    i_imem_gnt = 1'b1;
    @(negedge clk);
    i_imem_gnt = 1'b0;
    rst_n = 1'b0;
    m_pc = 32'h0; m_instret = 32'd0; m_err = 1'b0;
    #1;
    checks++;
    if (o_pc !== 32'h0 || o_instr_valid !== 1'b0 || o_imem_req !== 1'b0 || o_instret !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: pc=%h valid=%0b req=%0b instret=%0d required 0 0 0 0",
               o_pc, o_instr_valid, o_imem_req, o_instret);
    end
    @(negedge clk);
    rst_n         = 1'b1;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    clear_inputs();
    checks++;
    if (o_instr_valid !== 1'b0 || o_instr !== 32'h0 || o_pc !== 32'h0 || o_imem_req !== 1'b1) begin
      failures++;
      $display("FAIL stale_rvalid: valid=%0b instr=%h pc=%h req=%0b required 0 00000000 00000000 1",
               o_instr_valid, o_instr, o_pc, o_imem_req);
    end
    fetch_one(1, 1, 32'h0000_0037);
    retire(1'b0, 32'h0);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_zero_wait();
    test_delayed();
    test_branch();
    test_wrap();
    test_random();
    test_misaligned();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
